rs232_tx_feeder: RTL and testbench
==================================

Name: rs232_tx_feeder

Overview:
- Byte-queue and pacing stage that sits directly upstream of the RS-232 transmitter.
- Accepts bytes from producer logic (scanner readout, debug printer) into a FIFO.
- Presents one byte at a time on the transmitter's data/send inputs as a one-cycle send pulse.
- The transmitter has no busy flag, so this block counts the transmitter's bit-clock ticks to decide when the frame is finished and the next byte may go.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- FRAME_TICKS, 11, tx_bit_tick pulses to wait after a send pulse before the next send (start + 8 data + stop + 1 mark guard).

Ports:
- clk  in  1  system clock (27 MHz); same clock as the transmitter.
- reset  in  1  asynchronous, active-low reset.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe; one byte per cycle.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  ADDR_W+1  current FIFO occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- busy  out  1  a frame is in flight (FSM not IDLE).
- tx_data  out  8  byte to the transmitter's data input.
- tx_send  out  1  one-cycle send pulse to the transmitter's send input.
- tx_bit_tick  in  1  transmitter's bit-clock output; one-cycle pulse per bit period.

Behaviour:
- Reset (reset=0, asynchronous): FIFO pointers and level = 0, empty=1, full=0, overflow=0, busy=0, tx_send=0, tx_data=8'h00, tick counter = 0, FSM in IDLE.
- Release of reset is synchronous to clk.
- Reset asserted mid-frame: the frame is abandoned and queued bytes are lost. The transmitter's own reset must be driven coherently by the top level.
- FIFO write:
  - wr_en & !full: write mem[wptr], wptr wraps modulo DEPTH, level+1.
  - wr_en & full: byte dropped, overflow set to 1 (cleared only by reset).
- FIFO pop: performed only by the FSM.
- Same-cycle write and pop: level unchanged, both pointers advance. Allowed when full, because the pop frees a slot in the same edge.
- full and empty are registered and consistent with level on every cycle.
- FSM states:
  - IDLE: when !empty, pop the head byte. On the same edge set tx_data to that byte and tx_send=1, clear the tick counter, go to WAIT.
  - WAIT: tx_send returns to 0 after exactly one cycle; tx_data is held stable for the whole frame. Each tx_bit_tick=1 increments the counter. On the edge that samples the FRAME_TICKS-th tick, go to IDLE.
- Back-to-back frames: the next send pulse can occur on the edge immediately after returning to IDLE.
- Latency: a byte written into an empty FIFO while IDLE produces tx_send=1 in the cycle after the edge that sampled wr_en (1 cycle).
- A tx_bit_tick in the same cycle as tx_send is not counted. The counter starts on ticks sampled in WAIT.
- busy = (state != IDLE).

Optional Feature:
- Macro: TX_CRLF_EN.
- Defined: when the popped byte is 8'h0A, the FSM first sends 8'h0D as a full frame through an extra state CR_WAIT. It then sends 8'h0A without popping again. busy stays 1 across both frames.
- Not defined: bytes are sent verbatim, and CR_WAIT plus its logic are absent.

Test Plan:
- Reset: hold reset=0 with wr_en toggling -> empty=1, level=0, tx_send=0, tx_data=8'h00, overflow=0. After release, no tx_send until a write occurs.
- Single byte: write 8'h41 while idle, tick every 234 clk -> tx_send high for exactly 1 cycle, one cycle after the write, with tx_data=8'h41. busy falls on the edge sampling the 11th tick.
- Burst with DEPTH=4: write 8'h01..8'h06 on consecutive cycles -> 8'h01 pops immediately. 8'h02..8'h05 fill the FIFO (full=1). 8'h06 is dropped and overflow=1. Sends occur in order 01..05, spaced exactly 11 ticks apart.
- Simultaneous write/pop at full: with FIFO full and the FSM returning to IDLE, wr_en=1 -> the write is accepted, level stays at DEPTH, and overflow stays 0.
- Reset mid-frame: assert reset after tick 5 of a frame with 3 bytes queued -> all outputs take reset values asynchronously, and there is no further tx_send after release.
- TX_CRLF_EN defined: write 8'h0A -> two send pulses 11 ticks apart with tx_data 8'h0D then 8'h0A, and level decrements by 1. Undefined: a single send of 8'h0A.

Source files
------------

// File: rtl/rs232_tx_feeder_if.sv
// Purpose : bundles the producer-side FIFO signals and the transmitter-side pacing
//           signals of rs232_tx_feeder into one interface (master = producer/transmitter
//           environment, slave = the feeder itself).
// Latency : n/a (wires only).
// Backpressure: full/overflow toward the producer; tx_bit_tick paces the send side.
// Signals:
//   wr_data[7:0], wr_en        producer -> feeder enqueue
//   full, empty, level, overflow, busy   feeder status
//   tx_data[7:0], tx_send      feeder -> transmitter data and send pulse
//   tx_bit_tick                transmitter bit-clock pulse -> feeder
interface rs232_tx_feeder_if #(
    parameter int ADDR_W = 4
) ();
    logic [7:0]      wr_data;
    logic            wr_en;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] level;
    logic            overflow;
    logic            busy;
    logic [7:0]      tx_data;
    logic            tx_send;
    logic            tx_bit_tick;

    modport master (
        output wr_data, wr_en, tx_bit_tick,
        input  full, empty, level, overflow, busy, tx_data, tx_send
    );

    modport slave (
        input  wr_data, wr_en, tx_bit_tick,
        output full, empty, level, overflow, busy, tx_data, tx_send
    );
endinterface

// File: rtl/rs232_tx_feeder.sv
// Purpose : byte FIFO plus frame pacer feeding an RS-232 transmitter that has no busy flag.
// Latency : a byte written to an empty, idle FIFO is popped on the following edge (send pulse one cycle later).
// Backpressure: producer sees full; writes while full (and no same-edge pop) are dropped and set sticky overflow.
// Ports:
//   clk    system clock, shared with the transmitter
//   reset  asynchronous active-low reset
//   bus    rs232_tx_feeder_if.slave (wr_data/wr_en in, status out, tx_data/tx_send out, tx_bit_tick in)
// Optional build macro TX_CRLF_EN: a popped 8'h0A is sent as 8'h0D then 8'h0A (two frames, one pop).
module rs232_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int FRAME_TICKS = 11
) (
    input  logic               clk,
    input  logic               reset,
    rs232_tx_feeder_if.slave   bus
);

    localparam int CNT_W = $clog2(FRAME_TICKS + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
`ifdef TX_CRLF_EN
    localparam logic [1:0] ST_CR_WAIT = 2'd2;
`endif

    localparam logic [ADDR_W:0]  LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

    // Storage and FIFO bookkeeping
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;

    // Pacing FSM
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_send_q, tx_send_d;

    logic              pop;
    logic              push;
    logic              tick_counted;
    logic [7:0]        head;

    assign head = mem_q[rptr_q];
    assign pop  = (state_q == ST_IDLE) && !empty_q;
    // A pop on the same edge frees the slot the write lands in, so full does not block it.
    assign push = bus.wr_en && (!full_q || pop);
    // The tick coinciding with the send pulse belongs to the previous bit period.
    assign tick_counted = bus.tx_bit_tick && !tx_send_q;

    always_comb begin
        wptr_d     = push ? wptr_q + ADDR_W'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + ADDR_W'(1) : rptr_q;
        level_d    = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase
        full_d     = (level_d == LVL_FULL);
        empty_d    = (level_d == '0);
        overflow_d = overflow_q | (bus.wr_en & full_q & !pop);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_send_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_send_d = 1'b1;
                    cnt_d     = '0;
                    tx_data_d = head;
                    state_d   = ST_WAIT;
`ifdef TX_CRLF_EN
                    // Line feed goes out as CR first; the LF itself follows from CR_WAIT.
                    if (head == 8'h0A) begin
                        tx_data_d = 8'h0D;
                        state_d   = ST_CR_WAIT;
                    end
`endif
                end
            end
            ST_WAIT: begin
                if (tick_counted) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef TX_CRLF_EN
            ST_CR_WAIT: begin
                if (tick_counted) begin
                    if (cnt_q == CNT_LAST) begin
                        tx_data_d = 8'h0A;
                        tx_send_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_send_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_send  = tx_send_q;

endmodule

// File: tb/tb_rs232_tx_feeder.sv
// Purpose : self-checking bench for rs232_tx_feeder (DEPTH=4) against a queue-based reference model.
// Latency : model advances once per clock edge; outputs compared 1 time unit after each edge.
// Backpressure: model drops writes when its queue is full and no pop happens on that edge.
module tb_rs232_tx_feeder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int FT     = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rs232_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    rs232_tx_feeder #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .FRAME_TICKS(FT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queued bytes, frame-in-flight flag, ticks remaining in the frame.
    logic [7:0] mq[$];
    bit         m_busy;
    bit         m_send;
    bit         m_ovf;
    bit         m_lf;
    int         m_left;
    logic [7:0] m_data;

    logic [7:0] sends[$];
    int         cyc = 0;
    int         tick_period = 0;
    bit         tick_rand = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0;
        m_send = 1'b0;
        m_ovf  = 1'b0;
        m_lf   = 1'b0;
        m_left = 0;
        m_data = 8'h00;
    endtask

    task automatic model_edge(input bit wr, input logic [7:0] d, input bit tick);
        int         pre_size;
        bit         popped;
        bit         nsend;
        logic [7:0] b;
        pre_size = mq.size();
        popped   = 1'b0;
        nsend    = 1'b0;
        if (m_busy) begin
            if (tick && !m_send) m_left--;
            if (m_left == 0) begin
                if (m_lf) begin
                    m_data = 8'h0A;
                    nsend  = 1'b1;
                    m_left = FT;
                    m_lf   = 1'b0;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end else if (pre_size > 0) begin
            b      = mq.pop_front();
            popped = 1'b1;
            m_busy = 1'b1;
            m_left = FT;
            nsend  = 1'b1;
            m_data = b;
`ifdef TX_CRLF_EN
            if (b == 8'h0A) begin
                m_data = 8'h0D;
                m_lf   = 1'b1;
            end
`endif
        end
        if (wr) begin
            if (pre_size < DEPTH || popped) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        m_send = nsend;
    endtask

    task automatic check_all();
        chk("tx_send",  32'(bus.tx_send),  32'(m_send));
        chk("tx_data",  32'(bus.tx_data),  32'(m_data));
        chk("busy",     32'(bus.busy),     32'(m_busy));
        chk("level",    32'(bus.level),    32'(mq.size()));
        chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
        chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic cycle(input bit wr, input logic [7:0] d);
        bit tick;
        if (tick_rand) tick = ($urandom_range(3) == 0);
        else           tick = (tick_period > 0) && ((cyc % tick_period) == tick_period - 1);
        bus.wr_en       = wr;
        bus.wr_data     = d;
        bus.tx_bit_tick = tick;
        @(posedge clk);
        cyc++;
        if (!reset) model_reset();
        else        model_edge(wr, d, tick);
        #1;
        check_all();
        if (bus.tx_send === 1'b1) sends.push_back(bus.tx_data);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!m_busy && mq.size() == 0) break;
            cycle(1'b0, 8'h00);
        end
        chk("drain_busy",  32'(bus.busy),  32'd0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        reset           = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_data     = 8'h00;
        bus.tx_bit_tick = 1'b0;
        model_reset();

        // Reset held with wr_en toggling: outputs must stay at reset values.
        for (int i = 0; i < 6; i++) cycle(i[0], 8'hF0 + 8'(i));
        chk("rst_level", 32'(bus.level), 32'd0);

        // Release; no send without a write.
        reset = 1'b1;
        sends.delete();
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00);
        chk("idle_no_send", 32'(sends.size()), 32'd0);

        // Single byte, slow bit clock.
        tick_period = 234;
        cycle(1'b1, 8'h41);
        cycle(1'b0, 8'h00);
        chk("single_send", 32'(bus.tx_send), 32'd1);
        chk("single_data", 32'(bus.tx_data), 32'h41);
        cycle(1'b0, 8'h00);
        chk("single_pulse_width", 32'(bus.tx_send), 32'd0);
        drain(4000);
        chk("single_count", 32'(sends.size()), 32'd1);

        // Burst 01..06 into a 4-deep FIFO.
        tick_period = 3;
        sends.delete();
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i));
        chk("burst_full", 32'(bus.full),     32'd1);
        chk("burst_ovf",  32'(bus.overflow), 32'd1);
        drain(2000);
        chk("burst_count", 32'(sends.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("burst_order", 32'(sends[i]), 32'(i + 1));

        // Simultaneous write and pop while full.
        reset = 1'b0;
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        reset = 1'b1;
        tick_period = 2;
        sends.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h10 + 8'(i));
        for (int i = 0; i < 500; i++) begin
            if (!m_busy && mq.size() == DEPTH) break;
            cycle(1'b0, 8'h00);
        end
        chk("simul_pre_idle", 32'(bus.busy), 32'd0);
        chk("simul_pre_full", 32'(bus.full), 32'd1);
        cycle(1'b1, 8'h99);
        chk("simul_level", 32'(bus.level),    32'(DEPTH));
        chk("simul_ovf",   32'(bus.overflow), 32'd0);
        drain(2000);
        chk("simul_count", 32'(sends.size()), 32'd6);
        chk("simul_last",  32'(sends[5]),     32'h99);

        // Reset in the middle of a frame with three bytes queued.
        tick_period = 4;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20 + 8'(i));
        for (int i = 0; i < 500; i++) begin
            if (m_busy && m_left == FT - 5) break;
            cycle(1'b0, 8'h00);
        end
        chk("mid_queued", 32'(bus.level), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_send",  32'(bus.tx_send),  32'd0);
        chk("mid_rst_data",  32'(bus.tx_data),  32'h00);
        chk("mid_rst_busy",  32'(bus.busy),     32'd0);
        chk("mid_rst_level", 32'(bus.level),    32'd0);
        chk("mid_rst_empty", 32'(bus.empty),    32'd1);
        chk("mid_rst_full",  32'(bus.full),     32'd0);
        chk("mid_rst_ovf",   32'(bus.overflow), 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
        reset = 1'b1;
        sends.delete();
        for (int i = 0; i < 200; i++) cycle(1'b0, 8'h00);
        chk("post_rst_sends", 32'(sends.size()), 32'd0);

        // Line feed handling.
        tick_period = 3;
        sends.delete();
        cycle(1'b1, 8'h0A);
        drain(2000);
`ifdef TX_CRLF_EN
        chk("lf_count", 32'(sends.size()), 32'd2);
        chk("lf_first", 32'(sends[0]),     32'h0D);
        chk("lf_second", 32'(sends[1]),    32'h0A);
`else
        chk("lf_count", 32'(sends.size()), 32'd1);
        chk("lf_first", 32'(sends[0]),     32'h0A);
`endif

        // Randomized traffic and bit-clock jitter.
        tick_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            d = ($urandom_range(7) == 0) ? 8'h0A : 8'($urandom);
            cycle($urandom_range(2) == 0, d);
        end
        drain(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
